led_pattern_driver: RTL and testbench
=====================================

# led_pattern_driver

Multi-channel LED pattern generator: next generation of the single-channel enable flasher. One shared prescaler produces a slow tick. Each channel independently runs off, steady-on, blink or burst patterns, with a per-channel half-period measured in ticks. It sits between board status/control logic and the LED pins, and replaces per-LED flasher instances.

## Interface
- `TICK_DIV`, default 10_000_000: `led_clk` cycles per tick; legal range ≥ 2. Gives 10 Hz at 100 MHz.
- `NUM_CH`, default 4: number of LED channels; legal range ≥ 1.
- `PERIOD_W`, default 4: width of each per-channel half-period field.
- `led_clk`, input, 1: the single clock; all logic is on its rising edge.
- `led_rst`, input, 1: asynchronous, active-high reset.
- `led_en`, input, NUM_CH: per-channel enable.
- `led_mode`, input, 2*NUM_CH: channel i uses bits [2i+1:2i]. 00 = off, 01 = on, 10 = blink, 11 = burst.
- `led_period`, input, PERIOD_W*NUM_CH: per-channel half-period in ticks. A value of 0 is treated as 1.
- `led_burst`, input, 4*NUM_CH: per-channel flashes per burst. A value of 0 is treated as 1.
- `led_sync`, input, 1: single-cycle pulse that restarts the prescaler and all channels.
- `led_out`, output, NUM_CH: registered LED drive.
- `tick_out`, output, 1: registered one-cycle strobe, high on each tick.

## Operation
- **Prescaler**
  - Counter `pre` counts 0..TICK_DIV-1 and wraps.
  - `tick` is high for one cycle when `pre == TICK_DIV-1`.
  - `tick_out` is `tick` registered.
- **Per-channel state:** each channel holds
  - `ph`: PERIOD_W-bit tick counter;
  - `lvl`: current half-period level;
  - `fl`: 4-bit flash counter;
  - `gap`: 1-bit gap counter;
  - `mode_q`: registered copy of the channel's mode.
- **Restart:** a channel restarts when any of these occur:
  - `led_en[i]` falls or rises;
  - `led_mode` for the channel differs from `mode_q`;
  - `led_sync` is high.
- **Restart actions:** on the next edge set `ph = 0`, `lvl = 1`, `fl = 0`, `gap = 0`.
- **Half-period advance:** on each tick, if `ph == P-1` (P = effective period):
  - set `ph = 0`;
  - advance the pattern one half-period.
  - Otherwise set `ph = ph + 1`.
- **Disabled:** when `led_en[i] = 0`, `led_out[i] = 0` regardless of mode.
- **Off (00):** output 0.
- **On (01):** output 1.
- **Blink (10):**
  - `lvl` toggles every half-period.
  - Output = `lvl`; the first half-period after restart is on.
- **Burst (11):**
  - Emits B flashes (B = effective burst), each one half-period on and one half-period off.
  - Then a gap of 2 extra off half-periods, then repeats.
  - Cycle length is 2B+2 half-periods.
  - `fl` counts completed on/off pairs. When `fl == B`, `gap` runs for 2 half-periods, then `fl = 0`, `lvl = 1`.
- **Parameter changes:** a `led_period` or `led_burst` change without a mode change does not restart the channel.
  - The new value is compared on the next tick.
  - If `ph` is already ≥ new P-1, the half-period ends at that tick.
- **`led_sync` also:** sets `pre = 0` on the next edge. The first tick then follows TICK_DIV-1 cycles later, at `pre == TICK_DIV-1`.
- **Arithmetic:** all counters are unsigned and wrap only where stated. No counter overflows for legal parameters.

## Timing
- **Reset values:**
  - `led_out` = 0, `tick_out` = 0;
  - `pre`, `ph`, `fl`, `gap` = 0;
  - `lvl` = 1;
  - `mode_q` = 00.
- **First tick after reset release:** `tick` is high in cycle TICK_DIV (counting the first edge after release as cycle 1). `tick_out` follows one cycle later.
- **Latency to output:** a mode or enable change reaches `led_out` on the 2nd edge after the input changes: 1 edge to restart, 1 edge for the output register.
- **Half-period timing:** the level changes on the 2nd edge after the tick that ends the half-period.
- **Simultaneous tick and restart:** restart wins; `ph` goes to 0 and no advance occurs.
- **Simultaneous `led_sync` and tick:** `pre` goes to 0 and channels restart; no advance occurs.
- **Reset mid-pattern:** asynchronous clear of all state. Outputs are 0 immediately, without waiting for a clock edge.

## Test plan
For all scenarios: `TICK_DIV = 4`, `NUM_CH = 2`, `PERIOD_W = 4`.
- **Reset:** assert `led_rst` mid-blink → `led_out = 00` and `tick_out = 0` immediately. After release, `tick_out` pulses at cycles 5, 9, 13, …
- **Blink:** ch0 enabled, mode 10, period 2 → `led_out[0]` is high for 8 cycles, low for 8 cycles, repeating. The first rise is 2 edges after enable.
- **Burst:** ch1 enabled, mode 11, period 1, burst 3 → per 4-cycle tick the pattern is 1,0,1,0,1,0,0,0, repeating. This gives a 32-cycle period with 3 pulses.
- **Period 0 / burst 0:** blink period 0 behaves as period 1 (toggles every tick). Burst 0 gives 1 flash and then a 2-half-period gap.
- **Restart priority:** change ch0 mode from 10 to 11 on a cycle where `tick = 1` → the channel restarts on the first on half-period, with no extra advance. `ch1` is unaffected.
- **Sync:** pulse `led_sync` mid-pattern → `pre` is 0 on the next edge, the next `tick_out` comes 4 cycles after the sync edge, and both channels restart with the on level.

Source files
------------

// File: rtl/led_pattern_driver.sv
// led_pattern_driver: multi-channel LED pattern generator.
//   One shared prescaler produces a one-cycle tick every TICK_DIV clocks.
//   Each channel runs off / on / blink / burst patterns independently.
//   The half-period of each channel is counted in ticks.
// Ports:
//   led_clk     : clock, all logic on the rising edge
//   led_rst     : asynchronous active-high reset
//   led_en      : [NUM_CH] per-channel enable
//   led_mode    : [2*NUM_CH] per-channel mode, 00 off / 01 on / 10 blink / 11 burst
//   led_period  : [PERIOD_W*NUM_CH] per-channel half-period in ticks (0 acts as 1)
//   led_burst   : [4*NUM_CH] per-channel flashes per burst (0 acts as 1)
//   led_sync    : restart pulse for the prescaler and all channels
//   led_out     : [NUM_CH] registered LED drive
//   tick_out    : registered tick strobe

// Per-channel pattern engine.
module led_pattern_ch #(
  parameter int PERIOD_W = 4
) (
  input  logic                led_clk,
  input  logic                led_rst,
  input  logic                tick_i,
  input  logic                sync_i,
  input  logic                en_i,
  input  logic [1:0]          mode_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [3:0]          burst_i,
  output logic                out_o
);
  logic                en_q;
  logic [1:0]          mode_q;
  logic [PERIOD_W-1:0] ph_q, ph_d;
  logic                lvl_q, lvl_d;
  logic [3:0]          fl_q, fl_d;
  logic                gap_q, gap_d;
  logic                out_q, out_d;

  logic                restart;
  logic [PERIOD_W-1:0] p_last;
  logic [3:0]          b_eff;

  // Zero period / burst behave as one.
  assign p_last  = (period_i == '0) ? '0 : period_i - 1'b1;
  assign b_eff   = (burst_i == 4'd0) ? 4'd1 : burst_i;
  assign restart = (en_i != en_q) | (mode_i != mode_q) | sync_i;

  always_comb begin
    ph_d  = ph_q;
    lvl_d = lvl_q;
    fl_d  = fl_q;
    gap_d = gap_q;
    if (restart) begin
      // Restart beats a coincident tick: no advance this edge.
      ph_d  = '0;
      lvl_d = 1'b1;
      fl_d  = 4'd0;
      gap_d = 1'b0;
    end else if (tick_i) begin
      // >= so a shortened period ends the current half-period right away.
      if (ph_q >= p_last) begin
        ph_d = '0;
        case (mode_q)
          2'b10: lvl_d = ~lvl_q;
          2'b11: begin
            if (fl_q >= b_eff) begin
              // Two off half-periods of gap, then start a new burst.
              if (!gap_q) begin
                gap_d = 1'b1;
              end else begin
                gap_d = 1'b0;
                fl_d  = 4'd0;
                lvl_d = 1'b1;
              end
            end else if (lvl_q) begin
              lvl_d = 1'b0;
            end else begin
              // Off half of a pair done; stay off if that was the last flash.
              fl_d  = fl_q + 4'd1;
              lvl_d = ((fl_q + 4'd1) < b_eff);
            end
          end
          default: ;
        endcase
      end else begin
        ph_d = ph_q + 1'b1;
      end
    end
  end

  assign out_d = en_q & ((mode_q == 2'b01) | (mode_q[1] & lvl_q));
  assign out_o = out_q;

  always_ff @(posedge led_clk or posedge led_rst) begin
    if (led_rst) begin
      en_q   <= 1'b0;
      mode_q <= 2'b00;
      ph_q   <= '0;
      lvl_q  <= 1'b1;
      fl_q   <= 4'd0;
      gap_q  <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      en_q   <= en_i;
      mode_q <= mode_i;
      ph_q   <= ph_d;
      lvl_q  <= lvl_d;
      fl_q   <= fl_d;
      gap_q  <= gap_d;
      out_q  <= out_d;
    end
  end
endmodule

module led_pattern_driver #(
  parameter int TICK_DIV = 10_000_000,
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 4
) (
  input  logic                         led_clk,
  input  logic                         led_rst,
  input  logic [NUM_CH-1:0]            led_en,
  input  logic [2*NUM_CH-1:0]          led_mode,
  input  logic [PERIOD_W*NUM_CH-1:0]   led_period,
  input  logic [4*NUM_CH-1:0]          led_burst,
  input  logic                         led_sync,
  output logic [NUM_CH-1:0]            led_out,
  output logic                         tick_out
);
  localparam int                PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  logic             tick_out_q;

  assign tick     = (pre_q == PRE_LAST);
  assign pre_d    = (led_sync | tick) ? '0 : pre_q + 1'b1;
  assign tick_out = tick_out_q;

  always_ff @(posedge led_clk or posedge led_rst) begin
    if (led_rst) begin
      pre_q      <= '0;
      tick_out_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      tick_out_q <= tick;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_pattern_ch #(.PERIOD_W(PERIOD_W)) u_ch (
      .led_clk  (led_clk),
      .led_rst  (led_rst),
      .tick_i   (tick),
      .sync_i   (led_sync),
      .en_i     (led_en[i]),
      .mode_i   (led_mode[2*i +: 2]),
      .period_i (led_period[PERIOD_W*i +: PERIOD_W]),
      .burst_i  (led_burst[4*i +: 4]),
      .out_o    (led_out[i])
    );
  end
endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver with TICK_DIV=4, NUM_CH=2, PERIOD_W=4.
// n counts rising edges after reset release; outputs are sampled 1 ns after each edge.
module tb_led_pattern_driver;
  localparam int TICK_DIV = 4;
  localparam int NUM_CH   = 2;
  localparam int PERIOD_W = 4;

  logic                       led_clk = 1'b0;
  logic                       led_rst;
  logic [NUM_CH-1:0]          led_en;
  logic [2*NUM_CH-1:0]        led_mode;
  logic [PERIOD_W*NUM_CH-1:0] led_period;
  logic [4*NUM_CH-1:0]        led_burst;
  logic                       led_sync;
  logic [NUM_CH-1:0]          led_out;
  logic                       tick_out;

  int vec = 0;
  int err = 0;
  int n   = 0;

  led_pattern_driver #(.TICK_DIV(TICK_DIV), .NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W)) dut (
    .led_clk(led_clk), .led_rst(led_rst), .led_en(led_en), .led_mode(led_mode),
    .led_period(led_period), .led_burst(led_burst), .led_sync(led_sync),
    .led_out(led_out), .tick_out(tick_out)
  );

  always #5 led_clk = ~led_clk;

  function automatic bit burst3(int h);
    return (h == 0) || (h == 2) || (h == 4);
  endfunction

  function automatic bit burst2(int h);
    return (h == 0) || (h == 2);
  endfunction

  task automatic step();
    @(posedge led_clk);
    #1;
    n++;
  endtask

  task automatic do_reset();
    led_rst = 1'b1; led_en = '0; led_mode = '0; led_period = '0;
    led_burst = '0; led_sync = 1'b0;
    repeat (2) @(posedge led_clk);
    @(negedge led_clk);
    led_rst = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    do_reset();
    led_en = 2'b01; led_mode = 4'b0010; led_period = 8'h02;
    repeat (5) step();
    vec++;
    if (led_out !== 2'b01) begin
      err++; $display("FAIL pre_reset_out n=%0d got=%b exp=01", n, led_out);
    end
    #2 led_rst = 1'b1;
    #1;
    vec++;
    if (led_out !== 2'b00 || tick_out !== 1'b0) begin
      err++; $display("FAIL async_reset got out=%b tick=%b exp out=00 tick=0", led_out, tick_out);
    end
    step();
    vec++;
    if (led_out !== 2'b00 || tick_out !== 1'b0) begin
      err++; $display("FAIL reset_held got out=%b tick=%b exp out=00 tick=0", led_out, tick_out);
    end
    @(negedge led_clk);
    led_rst = 1'b0; led_en = '0; led_mode = '0;
    n = 0;
    for (int k = 0; k < 13; k++) begin
      step();
      vec++;
      if (tick_out !== ((n % 4) == 0) || led_out !== 2'b00) begin
        err++; $display("FAIL reset_tick n=%0d got tick=%b out=%b exp tick=%b out=00",
                        n, tick_out, led_out, ((n % 4) == 0));
      end
    end
  endtask

  task automatic test_blink();
    logic [1:0] e;
    do_reset();
    led_en = 2'b01; led_mode = 4'b0010; led_period = 8'h02;
    for (int k = 0; k < 40; k++) begin
      step();
      e = {1'b0, (n >= 2) && (((n - 1) / 8) % 2 == 0)};
      vec++;
      if (led_out !== e) begin
        err++; $display("FAIL blink n=%0d got=%b exp=%b", n, led_out, e);
      end
    end
  endtask

  task automatic test_burst();
    logic [1:0] e;
    do_reset();
    led_en = 2'b10; led_mode = 4'b1100; led_period = 8'h10; led_burst = 8'h30;
    for (int k = 0; k < 40; k++) begin
      step();
      e = {(n >= 2) && burst3(((n - 1) / 4) % 8), 1'b0};
      vec++;
      if (led_out !== e) begin
        err++; $display("FAIL burst n=%0d got=%b exp=%b", n, led_out, e);
      end
    end
  endtask

  task automatic test_zero_values();
    logic [1:0] e;
    do_reset();
    led_en = 2'b11; led_mode = 4'b1110; led_period = 8'h00; led_burst = 8'h00;
    for (int k = 0; k < 32; k++) begin
      step();
      e = {(n >= 2) && (((n - 1) / 4) % 4 == 0), (n >= 2) && (((n - 1) / 4) % 2 == 0)};
      vec++;
      if (led_out !== e) begin
        err++; $display("FAIL zero_period_burst n=%0d got=%b exp=%b", n, led_out, e);
      end
    end
  endtask

  task automatic test_restart_priority();
    logic [1:0] e;
    logic       e0;
    do_reset();
    led_en = 2'b11; led_mode = 4'b1110; led_period = 8'h12; led_burst = 8'h32;
    for (int k = 0; k < 72; k++) begin
      step();
      // Edge 15 leaves pre at 3, so the mode change lands in a tick cycle.
      if (n == 15) led_mode = 4'b1111;
      if (n <= 16) e0 = (n >= 2) && (((n - 1) / 8) % 2 == 0);
      else         e0 = burst2(((n - 17) / 8) % 6);
      e = {(n >= 2) && burst3(((n - 1) / 4) % 8), e0};
      vec++;
      if (led_out !== e) begin
        err++; $display("FAIL restart_priority n=%0d got=%b exp=%b", n, led_out, e);
      end
    end
  endtask

  task automatic test_sync();
    logic [1:0] e;
    logic       et;
    do_reset();
    led_en = 2'b11; led_mode = 4'b1110; led_period = 8'h12; led_burst = 8'h30;
    for (int k = 0; k < 50; k++) begin
      step();
      if (n == 13) led_sync = 1'b1;
      if (n == 14) led_sync = 1'b0;
      if (n <= 14) begin
        e  = {(n >= 2) && burst3(((n - 1) / 4) % 8), (n >= 2) && (((n - 1) / 8) % 2 == 0)};
        et = ((n % 4) == 0);
      end else begin
        e  = {burst3(((n - 15) / 4) % 8), (((n - 15) / 8) % 2 == 0)};
        et = (((n - 14) % 4) == 0);
      end
      vec++;
      if (led_out !== e || tick_out !== et) begin
        err++; $display("FAIL sync n=%0d got out=%b tick=%b exp out=%b tick=%b",
                        n, led_out, tick_out, e, et);
      end
    end
  endtask

  initial begin
    led_rst = 1'b1; led_en = '0; led_mode = '0; led_period = '0;
    led_burst = '0; led_sync = 1'b0;
    test_reset();
    test_blink();
    test_burst();
    test_zero_values();
    test_restart_priority();
    test_sync();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
